// File: rtl/seq_sr32_if.sv
// rtl/seq_sr32_if.sv - start/done handshake bundle between the control FSM and seq_sr32
interface seq_sr32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             arith;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             busy;

  modport master (
    output start, arith, a, b,
    input  out, done, busy
  );

  modport slave (
    input  start, arith, a, b,
    output out, done, busy
  );
endinterface

// File: rtl/seq_sr32.sv
// rtl/seq_sr32.sv - multi-cycle 32-bit logical/arithmetic right shifter, one log stage per clock
// Optional SEQ_SR32_EARLY_EXIT_EN: finish as soon as no higher shift-amount bits remain.
module seq_sr32 #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  seq_sr32_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   acc, acc_nx;
  logic [WIDTH-1:0]   out_r, out_nx;
  logic [SHAMT_W-1:0] amt, amt_nx;
  logic [2:0]         k, k_nx;
  logic               fill, fill_nx;
  logic               ovf;
  logic               a_fill;
  logic               last;
  logic [WIDTH-1:0]   stage;
  logic signed [WIDTH:0] ext;
  logic signed [WIDTH:0] ext_sh;
`ifdef SEQ_SR32_EARLY_EXIT_EN
  logic [SHAMT_W-1:0] hi_mask;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      amt   <= '0;
      k     <= '0;
      fill  <= 1'b0;
      out_r <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      amt   <= amt_nx;
      k     <= k_nx;
      fill  <= fill_nx;
      out_r <= out_nx;
    end
  end

  // Prepending the fill bit lets one arithmetic shift supply the vacated upper bits.
  always_comb begin
    ext    = {fill, acc};
    ext_sh = ext >>> (32'd1 << k);
    stage  = amt[k] ? ext_sh[WIDTH-1:0] : acc;
  end

  always_comb begin
    ovf    = |bus.b[WIDTH-1:SHAMT_W];
    a_fill = bus.arith & bus.a[WIDTH-1];
`ifdef SEQ_SR32_EARLY_EXIT_EN
    hi_mask = {{(SHAMT_W-1){1'b1}}, 1'b0} << k;
    last    = (k == 3'(SHAMT_W-1)) || ((amt & hi_mask) == '0);
`else
    last    = (k == 3'(SHAMT_W-1));
`endif
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    amt_nx   = amt;
    k_nx     = k;
    fill_nx  = fill;
    out_nx   = out_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          fill_nx  = a_fill;
          k_nx     = '0;
          state_nx = SHIFT;
          // Overflowed amounts shift everything out: preload the fill pattern, no stages active.
          if (ovf) begin
            acc_nx = {WIDTH{a_fill}};
            amt_nx = '0;
          end else begin
            acc_nx = bus.a;
            amt_nx = bus.b[SHAMT_W-1:0];
          end
        end
      end
      SHIFT: begin
        acc_nx = stage;
        if (last) begin
          state_nx = DONE;
          out_nx   = stage;
        end else begin
          k_nx = k + 3'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.out  = out_r;
  assign bus.done = (state == DONE);
  assign bus.busy = (state != IDLE);

endmodule
